// File: rtl/axi_pkg.sv
// axi_pkg: shared FSM encodings, AXI burst codes and master indices for the arbiter
package axi_pkg;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] BURST_WRAP = 2'b10;

    localparam logic MST_M0 = 1'b0;
    localparam logic MST_M1 = 1'b1;

endpackage

// File: rtl/axi_rr_picker.sv
// axi_rr_picker: two-way read grant picker; ARB_ROUND_ROBIN_EN turns the M1-wins tie-break into round robin
module axi_rr_picker
    import axi_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       take,
    output logic       any,
    output logic       pick
);

    logic last_grant;
    logic tie_pick;

    // remember the winner each time the read FSM accepts a grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_grant <= MST_M0;
        else if (take) last_grant <= pick;
    end

`ifdef ARB_ROUND_ROBIN_EN
    assign tie_pick = ~last_grant;
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign tie_pick = MST_M1;
`endif

    assign any  = |req;
    assign pick = &req ? tie_pick : req[1];

endmodule

// File: rtl/axi_arbiter.sv
// axi_arbiter: two-master AXI3 arbiter (m0 read-only, m1 read/write), one read and one write outstanding; macro ARB_ROUND_ROBIN_EN
module axi_arbiter
    import axi_pkg::*;
#(
    parameter logic [3:0] M0_ID = 4'd0,
    parameter logic [3:0] M1_ID = 4'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] m0_araddr,
    input  logic [3:0]  m0_arlen,
    input  logic [2:0]  m0_arsize,
    input  logic [1:0]  m0_arburst,
    input  logic        m0_arvalid,
    output logic        m0_arready,
    output logic [31:0] m0_rdata,
    output logic        m0_rlast,
    output logic        m0_rvalid,
    output logic [1:0]  m0_rresp,
    input  logic        m0_rready,
    input  logic [31:0] m1_araddr,
    input  logic [3:0]  m1_arlen,
    input  logic [2:0]  m1_arsize,
    input  logic [1:0]  m1_arburst,
    input  logic        m1_arvalid,
    output logic        m1_arready,
    output logic [31:0] m1_rdata,
    output logic        m1_rlast,
    output logic        m1_rvalid,
    output logic [1:0]  m1_rresp,
    input  logic        m1_rready,
    input  logic [31:0] m1_awaddr,
    input  logic [3:0]  m1_awlen,
    input  logic [2:0]  m1_awsize,
    input  logic [1:0]  m1_awburst,
    input  logic        m1_awvalid,
    output logic        m1_awready,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    input  logic        m1_wlast,
    input  logic        m1_wvalid,
    output logic        m1_wready,
    output logic        m1_bvalid,
    output logic [1:0]  m1_bresp,
    input  logic        m1_bready,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic [3:0]  arqos,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic [3:0]  awqos,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    r_state_t   r_state;
    w_state_t   w_state;
    logic       grant;
    logic       any;
    logic       pick;
    logic       r_addr;
    logic       r_data;
    logic [1:0] elig;

    // m1 reads wait for its own write to finish so they observe the written data
    assign elig = {m1_arvalid && w_state == W_IDLE, m0_arvalid};

    axi_rr_picker u_picker (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (elig),
        .take  (r_state == R_IDLE && any),
        .any   (any),
        .pick  (pick)
    );

    // read FSM: grant is frozen from acceptance until the last beat returns
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            grant   <= MST_M0;
        end else begin
            case (r_state)
                R_IDLE: if (any) begin
                    grant   <= pick;
                    r_state <= R_ADDR;
                end
                R_ADDR:  if (arready) r_state <= R_DATA;
                R_DATA:  if (rvalid && rready && rlast) r_state <= R_IDLE;
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign r_addr     = r_state == R_ADDR;
    assign r_data     = r_state == R_DATA;
    assign arvalid    = r_addr;
    assign arid       = grant ? M1_ID : M0_ID;
    assign araddr     = grant ? m1_araddr : m0_araddr;
    assign arlen      = grant ? m1_arlen : m0_arlen;
    assign arsize     = grant ? m1_arsize : m0_arsize;
    assign arburst    = grant ? m1_arburst : m0_arburst;
    assign arlock     = '0;
    assign arcache    = '0;
    assign arprot     = '0;
    assign arqos      = '0;
    assign m0_arready = r_addr && !grant && arready;
    assign m1_arready = r_addr && grant && arready;
    assign rready     = r_data && (grant ? m1_rready : m0_rready);
    assign m0_rvalid  = r_data && !grant && rvalid;
    assign m1_rvalid  = r_data && grant && rvalid;
    assign m0_rdata   = rdata;
    assign m1_rdata   = rdata;
    assign m0_rlast   = rlast;
    assign m1_rlast   = rlast;
    assign m0_rresp   = rresp;
    assign m1_rresp   = rresp;

    // write FSM: m1 only, walks address, data and response phases in order
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) w_state <= W_IDLE;
        else begin
            case (w_state)
                W_IDLE: if (m1_awvalid) w_state <= W_ADDR;
                W_ADDR: if (awvalid && awready) w_state <= W_DATA;
                W_DATA: if (wvalid && wready && wlast) w_state <= W_RESP;
                W_RESP: if (bvalid && bready) w_state <= W_IDLE;
            endcase
        end
    end

    assign awvalid    = w_state == W_ADDR && m1_awvalid;
    assign m1_awready = w_state == W_ADDR && awready;
    assign wvalid     = w_state == W_DATA && m1_wvalid;
    assign m1_wready  = w_state == W_DATA && wready;
    assign m1_bvalid  = w_state == W_RESP && bvalid;
    assign bready     = w_state == W_RESP && m1_bready;
    assign awid       = M1_ID;
    assign wid        = M1_ID;
    assign awaddr     = m1_awaddr;
    assign awlen      = m1_awlen;
    assign awsize     = m1_awsize;
    assign awburst    = m1_awburst;
    assign awlock     = '0;
    assign awcache    = '0;
    assign awprot     = '0;
    assign awqos      = '0;
    assign wdata      = m1_wdata;
    assign wstrb      = m1_wstrb;
    assign wlast      = m1_wlast;
    assign m1_bresp   = bresp;

endmodule

// File: tb/tb_axi_arbiter.sv
// tb_axi_arbiter: directed checks of grant order, latency, write ordering and reset abandonment
module tb_axi_arbiter;
    import axi_pkg::*;

    logic        clk, rst_n;
    logic [31:0] m0_araddr, m1_araddr, m1_awaddr, m1_wdata;
    logic [3:0]  m0_arlen, m1_arlen, m1_awlen, m1_wstrb;
    logic [2:0]  m0_arsize, m1_arsize, m1_awsize;
    logic [1:0]  m0_arburst, m1_arburst, m1_awburst;
    logic        m0_arvalid, m0_arready, m0_rlast, m0_rvalid, m0_rready;
    logic        m1_arvalid, m1_arready, m1_rlast, m1_rvalid, m1_rready;
    logic [31:0] m0_rdata, m1_rdata;
    logic [1:0]  m0_rresp, m1_rresp, m1_bresp;
    logic        m1_awvalid, m1_awready, m1_wlast, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
    logic [3:0]  arid, arlen, arcache, arqos, awid, awlen, awcache, awqos, wid, wstrb;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [2:0]  arsize, arprot, awsize, awprot;
    logic [1:0]  arburst, arlock, rresp, awburst, awlock, bresp;
    logic        arvalid, arready, rlast, rvalid, rready, awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    axi_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_rdata(m0_rdata), .m0_rlast(m0_rlast),
        .m0_rvalid(m0_rvalid), .m0_rresp(m0_rresp), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_rdata(m1_rdata), .m1_rlast(m1_rlast),
        .m1_rvalid(m1_rvalid), .m1_rresp(m1_rresp), .m1_rready(m1_rready),
        .m1_awaddr(m1_awaddr), .m1_awlen(m1_awlen), .m1_awsize(m1_awsize), .m1_awburst(m1_awburst),
        .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_wlast(m1_wlast), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_bvalid(m1_bvalid),
        .m1_bresp(m1_bresp), .m1_bready(m1_bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
        .arcache(arcache), .arprot(arprot), .arqos(arqos), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
        .awcache(awcache), .awprot(awprot), .awqos(awqos), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // memory slave: always ready, returns base+beat, holds bvalid back 5 cycles after wlast
    logic        r_act, b_pend;
    logic [3:0]  r_cnt, r_len;
    logic [31:0] r_base;
    logic [2:0]  b_cnt;
    assign rvalid = r_act;
    assign rdata  = r_base + {28'd0, r_cnt};
    assign rlast  = r_cnt == r_len;
    assign rresp  = 2'b00;
    assign bvalid = b_pend && b_cnt == 3'd0;
    assign bresp  = 2'b00;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act <= 1'b0; r_cnt <= '0; r_len <= '0; r_base <= '0; b_pend <= 1'b0; b_cnt <= '0;
        end else begin
            if (arvalid && arready) begin
                r_act <= 1'b1; r_cnt <= '0; r_len <= arlen; r_base <= araddr;
            end else if (rvalid && rready) begin
                if (rlast) r_act <= 1'b0;
                else r_cnt <= r_cnt + 4'd1;
            end
            if (wvalid && wready && wlast) begin
                b_pend <= 1'b1; b_cnt <= 3'd5;
            end else if (bvalid && bready) b_pend <= 1'b0;
            else if (b_cnt != 3'd0) b_cnt <= b_cnt - 3'd1;
        end
    end

    // monitor: logs handshakes that complete at the following rising edge
    logic [3:0]  ar_id[$];
    int          ar_cyc[$];
    int          rl_cyc[$];
    int          beats0 = 0, beats1 = 0, both = 0, b_cyc = -1;
    logic [31:0] last0 = '0;
    always @(negedge clk) begin
        if (arvalid && arready) begin
            ar_id.push_back(arid);
            ar_cyc.push_back(cyc);
        end
        if (m0_rvalid && m0_rready) begin
            beats0 = beats0 + 1;
            if (m0_rlast) begin
                last0 = m0_rdata;
                rl_cyc.push_back(cyc);
            end
        end
        if (m1_rvalid && m1_rready) begin
            beats1 = beats1 + 1;
            if (m1_rlast) rl_cyc.push_back(cyc);
        end
        if (m0_rvalid && m1_rvalid) both = both + 1;
        if (bvalid && bready) b_cyc = cyc;
    end

    int checks = 0, failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [11:0] handshakes();
        return {arvalid, rready, awvalid, wvalid, bready, m0_arready, m0_rvalid,
                m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid};
    endfunction

    task automatic rd(input logic m, input logic [31:0] a, input logic [3:0] l);
        int n = 0;
        if (m) begin
            m1_araddr = a; m1_arlen = l; m1_arsize = 3'd2; m1_arburst = BURST_INCR; m1_arvalid = 1'b1;
        end else begin
            m0_araddr = a; m0_arlen = l; m0_arsize = 3'd2; m0_arburst = BURST_INCR; m0_arvalid = 1'b1;
        end
        while (!(m ? m1_arready : m0_arready) && n < 200) begin
            tick();
            n++;
        end
        check("ar_wait_timeout", 32'(n >= 200), 32'd0);
        tick();
        if (m) m1_arvalid = 1'b0;
        else m0_arvalid = 1'b0;
    endtask

    task automatic wait_beats(input logic m, input int target);
        int n = 0;
        while ((m ? beats1 : beats0) < target && n < 500) begin
            tick();
            n++;
        end
        check("beat_wait_timeout", 32'(n >= 500), 32'd0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] l);
        int n = 0;
        m1_awaddr = a; m1_awlen = l; m1_awsize = 3'd2; m1_awburst = BURST_INCR; m1_awvalid = 1'b1;
        while (!m1_awready && n < 200) begin
            tick();
            n++;
        end
        check("aw_wait_timeout", 32'(n >= 200), 32'd0);
        check("awaddr", awaddr, a);
        check("awid", 32'(awid), 32'd1);
        tick();
        m1_awvalid = 1'b0;
        for (int b = 0; b <= int'(l); b++) begin
            m1_wdata = 32'hD000_0000 + 32'(b); m1_wstrb = 4'hF; m1_wlast = b == int'(l); m1_wvalid = 1'b1;
            n = 0;
            while (!m1_wready && n < 200) begin
                tick();
                n++;
            end
            check("w_wait_timeout", 32'(n >= 200), 32'd0);
            check("wid", 32'(wid), 32'd1);
            tick();
        end
        m1_wvalid = 1'b0;
        m1_wlast  = 1'b0;
        n = 0;
        while (!m1_bvalid && n < 200) begin
            tick();
            n++;
        end
        check("b_wait_timeout", 32'(n >= 200), 32'd0);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, q, r, b0, b1;
        logic exp_ids[4];
`ifdef ARB_ROUND_ROBIN_EN
        exp_ids = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_ids = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        m0_araddr = '0; m0_arlen = '0; m0_arsize = '0; m0_arburst = '0; m0_arvalid = 1'b0;
        m1_araddr = '0; m1_arlen = '0; m1_arsize = '0; m1_arburst = '0; m1_arvalid = 1'b0;
        m1_awaddr = '0; m1_awlen = '0; m1_awsize = '0; m1_awburst = '0; m1_awvalid = 1'b0;
        m1_wdata = '0; m1_wstrb = '0; m1_wlast = 1'b0; m1_wvalid = 1'b0;
        m0_rready = 1'b1; m1_rready = 1'b1; m1_bready = 1'b1;
        arready = 1'b1; awready = 1'b1; wready = 1'b1;
        rst_n = 1'b0;
        repeat (2) tick();
        check("reset_handshakes", 32'(handshakes()), 32'd0);
        rst_n = 1'b1;
        tick();

        // single m0 burst of 16 beats
        k = cyc; q = ar_id.size(); b0 = beats0; b1 = beats1;
        rd(1'b0, 32'h1FC0_0000, 4'd15);
        check("m0_ar_latency", 32'(ar_cyc[q] - k), 32'd1);
        check("m0_arid", 32'(ar_id[q]), 32'd0);
        wait_beats(1'b0, b0 + 16);
        tick();
        check("m0_beats", 32'(beats0 - b0), 32'd16);
        check("m0_last_data", last0, 32'h1FC0_000F);
        check("m1_no_beats", 32'(beats1 - b1), 32'd0);
        check("m0_back_idle", {29'd0, arvalid, rready, m0_rvalid}, 32'd0);

        // simultaneous m0/m1 request: m1 first, m0 one idle cycle after m1 rlast
        q = ar_id.size(); r = rl_cyc.size(); b0 = beats0; b1 = beats1;
        fork
            rd(1'b1, 32'h0000_1000, 4'd1);
            rd(1'b0, 32'h0000_2000, 4'd1);
        join
        wait_beats(1'b0, b0 + 2);
        tick();
        check("tie_first_m1", 32'(ar_id[q]), 32'd1);
        check("tie_second_m0", 32'(ar_id[q + 1]), 32'd0);
        check("tie_regrant_gap", 32'(ar_cyc[q + 1] - rl_cyc[r]), 32'd2);
        check("tie_m1_beats", 32'(beats1 - b1), 32'd2);

        // repeated ties: fixed priority starves m0, round robin alternates
        q = ar_id.size(); b0 = beats0; b1 = beats1;
        fork
            repeat (4) rd(1'b1, 32'h0000_3000, 4'd0);
            repeat (4) rd(1'b0, 32'h0000_4000, 4'd0);
        join
        wait_beats(1'b0, b0 + 4);
        wait_beats(1'b1, b1 + 4);
        tick();
        for (int i = 0; i < 4; i++) check("repeat_tie_grant", 32'(ar_id[q + i]), 32'(exp_ids[i]));

        // m1 write holds off m1 read until the response; m0 read runs alongside
        q = ar_id.size(); b0 = beats0; b1 = beats1;
        fork
            wr(32'h8000_0000, 4'd1);
            begin
                tick();
                rd(1'b1, 32'h8000_0000, 4'd0);
            end
            begin
                tick();
                rd(1'b0, 32'h0000_5000, 4'd1);
            end
        join
        wait_beats(1'b1, b1 + 1);
        tick();
        check("raw_m0_first", 32'(ar_id[q]), 32'd0);
        check("raw_m0_during_write", 32'(ar_cyc[q] < b_cyc), 32'd1);
        check("raw_m1_second", 32'(ar_id[q + 1]), 32'd1);
        check("raw_m1_after_b", 32'(ar_cyc[q + 1] - b_cyc), 32'd2);
        check("no_dual_rvalid", 32'(both), 32'd0);

        // reset in the middle of a 16-beat burst
        b0 = beats0;
        rd(1'b0, 32'h1FC0_0100, 4'd15);
        wait_beats(1'b0, b0 + 3);
        r = rl_cyc.size();
        rst_n = 1'b0;
        #1;
        check("midburst_reset_handshakes", 32'(handshakes()), 32'd0);
        repeat (2) tick();
        check("reset_held_handshakes", 32'(handshakes()), 32'd0);
        check("abandoned_no_rlast", 32'(rl_cyc.size() - r), 32'd0);
        rst_n = 1'b1;
        tick();
        k = cyc; q = ar_id.size(); b0 = beats0;
        rd(1'b0, 32'h1FC0_0200, 4'd3);
        check("post_reset_latency", 32'(ar_cyc[q] - k), 32'd1);
        check("post_reset_arid", 32'(ar_id[q]), 32'd0);
        wait_beats(1'b0, b0 + 4);
        tick();
        check("post_reset_last_data", last0, 32'h1FC0_0203);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_arbiter.md
AXI_ARBITER -- requirements
Module: axi_arbiter

Interface
REQ-001 Parameter M0_ID, default 4'd0: arid driven for instruction-side reads.
REQ-002 Parameter M1_ID, default 4'd1: arid, awid and wid driven for data-side transactions.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 m0_araddr/arlen/arsize/arburst/arvalid  in  32/4/3/2/1  instruction-side read address, read-only master.
REQ-006 m0_arready, m0_rdata/rlast/rvalid/rresp  out  1, 32/1/1/2  instruction-side read response; m0_rready  in  1.
REQ-007 m1_ar*, m1_arready, m1_r*, m1_rready  as REQ-005/006  data-side read port.
REQ-008 m1_aw{addr,len,size,burst,valid}, m1_w{data,strb,last,valid}, m1_bready  in  AXI3 widths  data-side write request.
REQ-009 m1_awready, m1_wready, m1_bvalid, m1_bresp  out  1/1/1/2  data-side write handshake returns.
REQ-010 ar*, r*, aw*, w*, b*  AXI3 master port toward memory, same widths; lock/cache/prot/qos tied 0.

Function
REQ-011 Read FSM states: R_IDLE, R_ADDR, R_DATA.
REQ-012 R_IDLE: if any eligible arvalid, latch grant (0/1), go R_ADDR next cycle; the grant never changes before R_IDLE.
REQ-013 R_ADDR: arvalid=1, ar* and arid muxed from the granted master; mX_arready = arready for the granted master only; go R_DATA on arvalid&arready.
REQ-014 R_DATA: r* routed to the granted master only, rready = granted mX_rready; the other master sees rvalid=0; go R_IDLE on rvalid&rready&rlast.
REQ-015 Exactly one read outstanding; request-to-arvalid latency is 1 cycle; R_DATA to R_IDLE to next grant costs 1 idle cycle.
REQ-016 Write FSM states: W_IDLE, W_ADDR, W_DATA, W_RESP; one write outstanding.
REQ-017 W_IDLE leaves to W_ADDR on m1_awvalid; aw* pass through in W_ADDR; go W_DATA on awvalid&awready.
REQ-018 In W_DATA, w* pass through; go W_RESP on wvalid&wready&wlast.
REQ-019 In W_RESP, b* pass through; go W_IDLE on bvalid&bready.
REQ-020 m1 read is ineligible while the write FSM is not W_IDLE (read-after-write ordering); m0 eligibility is unaffected.
REQ-021 An m1 read already granted is not blocked by an m1_awvalid raised later; read and write FSMs run concurrently.
REQ-022 Outside the owning state, every valid/ready output toward either side is 0; data outputs are don't-care.
REQ-023 Tie (both eligible in R_IDLE): M1 wins unless REQ-027 applies.

Reset
REQ-024 rst_n low: read FSM R_IDLE, write FSM W_IDLE, grant=0, last_grant=0.
REQ-025 During reset all valid/ready outputs are 0; an in-flight burst is abandoned with no completion signalled.
REQ-026 First eligible request after rst_n rises is granted per REQ-012 with no extra delay.

Configuration
REQ-027 ARB_ROUND_ROBIN_EN defined: on a tie, grant the master not equal to last_grant; last_grant updates at each R_IDLE to R_ADDR; undefined: fixed M1 priority, last_grant unused.

Structure
REQ-028 Shared package axi_pkg: read/write state enums, AXI burst constants (INCR=2'b01, WRAP=2'b10), master index constants.
REQ-029 Sub-module axi_rr_picker: 2-input grant picker, combinational, holding the last_grant register.

Verification
REQ-030 m0 arvalid, addr 0x1FC00000, arlen 15 -> arvalid next cycle, arid 0, 16 beats to m0 only, R_IDLE after rlast.
REQ-031 m0 and m1 arvalid together, fixed priority -> m1 first (arid 1), m0 granted 1 cycle after m1 rlast.
REQ-032 Same tie with ARB_ROUND_ROBIN_EN, repeated 4 times -> grants alternate 1,0,1,0.
REQ-033 m1 write to 0x80000000 with bvalid delayed 5 cycles, m1 read raised meanwhile -> read arvalid only after bvalid&bready; m0 read during the write proceeds.
REQ-034 rst_n low mid-R_DATA beat 3 of 16 -> all valids/readies 0 immediately; after release, a new m0 request is granted normally.
